// File: rtl/ex_mul_ctrl_if.sv
// Bundle of the multiply sequencer's pipeline-facing signals: the operand/start
// request, the borrowed execute-stage ALU override path and the result.
interface ex_mul_ctrl_if #(
    parameter int N = 64
);
    logic         start;
    logic [N-1:0] op_a;
    logic [N-1:0] op_b;
    logic [N-1:0] alu_result_in;
    logic         alu_own;
    logic [N-1:0] alu_a_out;
    logic [N-1:0] alu_b_out;
    logic [3:0]   alu_ctrl_out;
    logic         stall;
    logic         done;
    logic [N-1:0] product;

    // Pipeline / execute-stage side: issues the MUL and hosts the shared ALU.
    modport master (
        output start, op_a, op_b, alu_result_in,
        input  alu_own, alu_a_out, alu_b_out, alu_ctrl_out, stall, done, product
    );

    // Multiply sequencer side.
    modport slave (
        input  start, op_a, op_b, alu_result_in,
        output alu_own, alu_a_out, alu_b_out, alu_ctrl_out, stall, done, product
    );
endinterface

// File: rtl/ex_mul_ctrl.sv
// Multi-cycle shift-and-add multiplier for the execute stage. Each partial-sum
// add is done by the existing execute ALU through its override muxes, so the
// sequencer itself only holds the shift registers and the accumulator.
module ex_mul_ctrl #(
    parameter int N = 64
) (
    input logic          clk,
    input logic          reset,
    ex_mul_ctrl_if.slave bus
);
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_NONE = 4'b0000;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t       state;
    logic [N-1:0] acc;
    logic [N-1:0] mcand;
    logic [N-1:0] mplier;
    logic [N-1:0] product_q;
    logic         done_q;

    logic [N-1:0] acc_next;
    logic [N-1:0] mplier_shr;
    logic         run;

    // Next accumulator value: the ALU sum (acc + mcand) when this multiplier
    // bit is set, otherwise the accumulator is unchanged.
    always_comb begin
        acc_next   = mplier[0] ? bus.alu_result_in : acc;
        mplier_shr = mplier >> 1;
    end

    // Sequencer FSM: loads operands on start, iterates one multiplier bit per
    // cycle and stops as soon as no set bits remain, then pulses done.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            product_q <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        mcand  <= bus.op_a;
                        mplier <= bus.op_b;
                        acc    <= '0;
                        if (bus.op_b == '0) begin
                            // Nothing to add: the product is zero right away.
                            state     <= DONE;
                            product_q <= '0;
                            done_q    <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier_shr;
                    if (mplier_shr == '0) begin
                        state     <= DONE;
                        product_q <= acc_next;
                        done_q    <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // ALU override is only claimed while iterating; outside RUN the muxes
    // see zeros so the normal execute path is undisturbed.
    assign run              = (state == RUN);
    assign bus.alu_own      = run;
    assign bus.alu_a_out    = run ? acc   : '0;
    assign bus.alu_b_out    = run ? mcand : '0;
    assign bus.alu_ctrl_out = run ? ALU_ADD : ALU_NONE;

    // Stall is combinational so the pipeline freezes in the accept cycle.
    assign bus.stall   = reset & (((state == IDLE) & bus.start) | run);
    assign bus.done    = done_q;
    assign bus.product = product_q;
endmodule

// File: tb/tb_ex_mul_ctrl.sv
// Directed bench for ex_mul_ctrl with a behavioural model of the shared ALU.
module tb_ex_mul_ctrl;
    localparam int N = 64;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    logic [N-1:0] exp_q[$];
    int           lat_q[$];
    logic [N-1:0] prev_prod;

    ex_mul_ctrl_if #(.N(N)) bus ();

    ex_mul_ctrl #(.N(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Execute ALU model: adds when asked to, otherwise produces junk so a
    // result taken outside the override path is visible.
    assign bus.alu_result_in = (bus.alu_ctrl_out == 4'b0010) ?
                               (bus.alu_a_out + bus.alu_b_out) : 64'hBAD0_BAD0_BAD0_BAD0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int lat_of(input logic [N-1:0] b);
        int k;
        k = -1;
        for (int i = 0; i < N; i++) if (b[i]) k = i;
        return (k < 0) ? 1 : k + 2;
    endfunction

    // Issue one MUL at the current negedge and follow it to done.
    task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, input bit glitch);
        int           cyc;
        int           own_cnt;
        int           lat;
        bit           run_err;
        logic [N-1:0] e;
        logic [N-1:0] ab;
        ab = a * b;
        bus.start = 1'b1;
        bus.op_a  = a;
        bus.op_b  = b;
        #1;
        chk("accept_stall", bus.stall, 1);
        chk("accept_done_low", bus.done, 0);
        exp_q.push_back(ab);
        lat_q.push_back(lat_of(b));
        @(negedge clk);
        bus.start = 1'b0;
        bus.op_a  = {$urandom, $urandom};
        bus.op_b  = {$urandom, $urandom};
        cyc = 1;
        own_cnt = 0;
        run_err = 1'b0;
        if (b != '0) chk("product_held", bus.product, prev_prod);
        while (!bus.done && cyc < 200) begin
            if (bus.alu_own) own_cnt++;
            if (bus.stall !== 1'b1 || bus.alu_own !== 1'b1 || bus.alu_ctrl_out !== 4'b0010)
                run_err = 1'b1;
            if (glitch && cyc == 2) begin
                bus.start = 1'b1;
                bus.op_a  = 64'd5;
                bus.op_b  = 64'd1;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        bus.start = 1'b0;
        e   = exp_q.pop_front();
        lat = lat_q.pop_front();
        chk("done_latency", cyc, lat);
        chk("product", bus.product, e);
        chk("stall_in_done", bus.stall, 0);
        chk("alu_own_in_done", bus.alu_own, 0);
        chk("alu_own_cycles", own_cnt, lat - 1);
        chk("run_controls", run_err, 0);
        prev_prod = e;
    endtask

    initial begin
        int done_seen;
        int stall_seen;
        total = 0;
        bad = 0;
        prev_prod = '0;
        reset = 1'b0;
        bus.start = 1'b0;
        bus.op_a = '0;
        bus.op_b = '0;
        repeat (2) @(negedge clk);
        chk("rst_done", bus.done, 0);
        chk("rst_stall", bus.stall, 0);
        chk("rst_alu_own", bus.alu_own, 0);
        chk("rst_product", bus.product, 0);
        chk("rst_alu_a", bus.alu_a_out, 0);
        chk("rst_alu_ctrl", bus.alu_ctrl_out, 0);
        reset = 1'b1;
        @(negedge clk);

        do_op(64'd7, 64'd6, 1'b0);
        chk("product_42", bus.product, 64'd42);
        @(negedge clk);
        do_op(64'h1234, 64'd0, 1'b0);
        @(negedge clk);
        do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1'b0);
        chk("product_wrap", bus.product, 64'h8000_0000_0000_0000);
        @(negedge clk);
        do_op(-64'sd3, 64'd5, 1'b0);
        chk("product_neg", bus.product, 64'hFFFF_FFFF_FFFF_FFF1);
        @(negedge clk);
        do_op(64'd2, 64'd3, 1'b0);
        @(negedge clk);
        do_op(64'h1111, 64'hFF, 1'b1);

        // Abort an operation with reset in its third cycle.
        @(negedge clk);
        bus.start = 1'b1;
        bus.op_a  = 64'h55;
        bus.op_b  = 64'hF0;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("abort_stall", bus.stall, 0);
        chk("abort_alu_own", bus.alu_own, 0);
        chk("abort_product", bus.product, 0);
        chk("abort_done", bus.done, 0);
        reset = 1'b1;
        done_seen = 0;
        stall_seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.done) done_seen++;
            if (bus.stall || bus.alu_own) stall_seen++;
        end
        chk("abort_no_done", done_seen, 0);
        chk("abort_idle", stall_seen, 0);
        prev_prod = '0;
        do_op(64'd9, 64'd9, 1'b0);
        chk("product_81", bus.product, 64'd81);
        @(negedge clk);
        chk("done_one_cycle", bus.done, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
